// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and timing defaults for the SRAM arbiter
package sram_pkg;

  localparam int ADDR_W_DEF    = 24;
  localparam int RD_CYCLES_DEF = 4;
  localparam int WR_CYCLES_DEF = 5;
  localparam int MCU_GAP_DEF   = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNES_RD = 3'd1,
    ST_SNES_WR = 3'd2,
    ST_MCU_RD  = 3'd3,
    ST_MCU_WR  = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Access counter must reach the longer of the two access lengths.
  function automatic int cnt_width(input int rd, input int wr);
    int m;
    m = (rd > wr) ? rd : wr;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sram_strobe_gen.sv
// rtl/sram_strobe_gen.sv - chip strobe sequencer: counts one access and drives ce/oe/we/doe
module sram_strobe_gen
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_doe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              o_sample,
  output logic              o_last
);

  localparam int            CW     = cnt_width(RD_CYCLES, WR_CYCLES);
  localparam logic [CW-1:0] RD_LEN = CW'(RD_CYCLES);
  localparam logic [CW-1:0] WR_LEN = CW'(WR_CYCLES);
  localparam logic [CW-1:0] WE_LO  = CW'(2);
  localparam logic [CW-1:0] WE_HI  = CW'(WR_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_active;
  logic          r_we;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + CW'(1);
  assign o_last    = r_active && (r_cnt == (r_we ? WR_LEN : RD_LEN));
  assign o_sample  = r_active && !r_we && (r_cnt == RD_LEN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_we     <= 1'b0;
      ram_addr <= '0;
      ram_dout <= '0;
      ram_doe  <= 1'b0;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_we     <= i_we;
      r_cnt    <= CW'(1);
      ram_addr <= i_addr;
      ram_dout <= i_wdata;
      ram_doe  <= i_we;
      ram_ce_n <= 1'b0;
      ram_oe_n <= i_we;
      ram_we_n <= 1'b1;
    end else if (r_active) begin
      if (o_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
        ram_doe  <= 1'b0;
        ram_ce_n <= 1'b1;
        ram_oe_n <= 1'b1;
        ram_we_n <= 1'b1;
      end else begin
        r_cnt    <= w_cnt_nxt;
        // we_n is registered, so decide on the count the next cycle will carry
        ram_we_n <= !(r_we && (w_cnt_nxt >= WE_LO) && (w_cnt_nxt <= WE_HI));
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - SNES-priority, non-preemptive arbiter for the shared ROM/SRAM chip
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF,
  parameter int MCU_GAP   = MCU_GAP_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              snes_req,
  input  logic              snes_we,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic [7:0]        snes_wdata,
  output logic [7:0]        snes_rdata,
  output logic              snes_done,
  output logic              snes_overrun,
  input  logic              mcu_req,
  input  logic              mcu_we,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [7:0]        mcu_wdata,
  output logic [7:0]        mcu_rdata,
  output logic              mcu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_doe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  state_t            r_state;
  logic              r_pend_v;
  logic              r_pend_we;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [7:0]        r_pend_wdata;
  logic              r_start;
  logic              r_start_we;
  logic [ADDR_W-1:0] r_start_addr;
  logic [7:0]        r_start_wdata;
  logic [7:0]        r_gap_cnt;

  logic              w_last;
  logic              w_sample;
  logic              w_snes_any;
  logic              w_s_we;
  logic [ADDR_W-1:0] w_s_addr;
  logic [7:0]        w_s_wdata;
  logic              w_in_snes;
  logic              w_in_mcu;
  logic              w_slot;
  logic              w_go_snes;
  logic              w_go_mcu;

  // A request arriving this cycle is forwarded straight to the grant when nothing is pending.
  assign w_snes_any = r_pend_v || snes_req;
  assign w_s_we     = r_pend_v ? r_pend_we    : snes_we;
  assign w_s_addr   = r_pend_v ? r_pend_addr  : snes_addr;
  assign w_s_wdata  = r_pend_v ? r_pend_wdata : snes_wdata;

  assign w_in_snes  = (r_state == ST_SNES_RD) || (r_state == ST_SNES_WR);
  assign w_in_mcu   = (r_state == ST_MCU_RD)  || (r_state == ST_MCU_WR);
  assign w_slot     = (r_state == ST_IDLE) || (r_state == ST_GAP) ||
                      ((w_in_snes || w_in_mcu) && w_last);
  assign w_go_snes  = w_slot && w_snes_any;
  assign w_go_mcu   = (r_state == ST_IDLE) && !w_snes_any && mcu_req;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pend_v     <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      snes_overrun <= 1'b0;
    end else begin
      if (snes_req && r_pend_v) begin
        snes_overrun <= 1'b1;
      end
      if (w_go_snes) begin
        r_pend_v <= 1'b0;
      end else if (snes_req && !r_pend_v) begin
        r_pend_v     <= 1'b1;
        r_pend_we    <= snes_we;
        r_pend_addr  <= snes_addr;
        r_pend_wdata <= snes_wdata;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_start       <= 1'b0;
      r_start_we    <= 1'b0;
      r_start_addr  <= '0;
      r_start_wdata <= '0;
      r_gap_cnt     <= '0;
      snes_rdata    <= '0;
      mcu_rdata     <= '0;
      snes_done     <= 1'b0;
      mcu_ack       <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      snes_done <= w_last && w_in_snes;
      mcu_ack   <= w_last && w_in_mcu;
      if (w_sample && w_in_snes) begin
        snes_rdata <= ram_din;
      end
      if (w_sample && w_in_mcu) begin
        mcu_rdata <= ram_din;
      end
      if (w_go_snes) begin
        r_state       <= w_s_we ? ST_SNES_WR : ST_SNES_RD;
        r_start       <= 1'b1;
        r_start_we    <= w_s_we;
        r_start_addr  <= w_s_addr;
        r_start_wdata <= w_s_wdata;
      end else if (w_go_mcu) begin
        r_state       <= mcu_we ? ST_MCU_WR : ST_MCU_RD;
        r_start       <= 1'b1;
        r_start_we    <= mcu_we;
        r_start_addr  <= mcu_addr;
        r_start_wdata <= mcu_wdata;
      end else begin
        case (r_state)
          ST_SNES_RD, ST_SNES_WR: begin
            if (w_last) r_state <= ST_IDLE;
          end
          ST_MCU_RD, ST_MCU_WR: begin
            if (w_last) begin
              if (MCU_GAP == 0) begin
                r_state <= ST_IDLE;
              end else begin
                r_state   <= ST_GAP;
                r_gap_cnt <= 8'(MCU_GAP - 1);
              end
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == 8'd0) r_state <= ST_IDLE;
            else                   r_gap_cnt <= r_gap_cnt - 8'd1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  sram_strobe_gen #(
    .ADDR_W    (ADDR_W),
    .RD_CYCLES (RD_CYCLES),
    .WR_CYCLES (WR_CYCLES)
  ) u_strobe (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_start  (r_start),
    .i_we     (r_start_we),
    .i_addr   (r_start_addr),
    .i_wdata  (r_start_wdata),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_doe  (ram_doe),
    .ram_ce_n (ram_ce_n),
    .ram_oe_n (ram_oe_n),
    .ram_we_n (ram_we_n),
    .o_sample (w_sample),
    .o_last   (w_last)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed and randomized bench for sram_arbiter with a chip model
module tb_sram_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        snes_req = 1'b0, snes_we = 1'b0;
  logic [23:0] snes_addr = '0;
  logic [7:0]  snes_wdata = '0;
  logic [7:0]  snes_rdata;
  logic        snes_done, snes_overrun;
  logic        mcu_req = 1'b0, mcu_we = 1'b0;
  logic [23:0] mcu_addr = '0;
  logic [7:0]  mcu_wdata = '0;
  logic [7:0]  mcu_rdata;
  logic        mcu_ack;
  logic [23:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        ram_doe, ram_ce_n, ram_oe_n, ram_we_n;

  sram_arbiter #(.ADDR_W(24), .RD_CYCLES(4), .WR_CYCLES(5), .MCU_GAP(1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr), .snes_wdata(snes_wdata),
    .snes_rdata(snes_rdata), .snes_done(snes_done), .snes_overrun(snes_overrun),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_rdata(mcu_rdata), .mcu_ack(mcu_ack),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din), .ram_doe(ram_doe),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 CLK = ~CLK;

  // Chip contents as seen on the pads, and the contents the requests imply.
  logic [7:0]  pad_mem [logic [23:0]];
  logic [7:0]  ref_mem [logic [23:0]];
  logic [23:0] pool [4] = '{24'hC00010, 24'hE00001, 24'h000100, 24'h000200};

  int n_checks = 0, n_fail = 0;
  int snes_done_cnt = 0, mcu_ack_cnt = 0;
  int oe_run = 0, oe_last = 0, we_run = 0, we_last = 0, bad_we = 0;

  function automatic logic [7:0] init_val(input logic [23:0] a);
    return a[7:0] ^ a[23:16] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] pad_rd(input logic [23:0] a);
    if (pad_mem.exists(a)) return pad_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  always @(posedge CLK) begin
    if (RST_N && !ram_ce_n && !ram_we_n) pad_mem[ram_addr] = ram_dout;
  end

  always @(negedge CLK) begin
    ram_din = (!ram_ce_n && !ram_oe_n) ? pad_rd(ram_addr) : 8'h00;
    if (snes_done) snes_done_cnt++;
    if (mcu_ack) mcu_ack_cnt++;
    if (!ram_oe_n) oe_run++;
    else if (oe_run != 0) begin oe_last = oe_run; oe_run = 0; end
    if (!ram_we_n) we_run++;
    else if (we_run != 0) begin we_last = we_run; we_run = 0; end
    if (!ram_we_n && (!ram_doe || ram_ce_n || !ram_oe_n)) bad_we++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snes_op(input logic we, input logic [23:0] a, input logic [7:0] d,
                         output int lat, output logic seen);
    snes_we = we; snes_addr = a; snes_wdata = d; snes_req = 1'b1;
    tick();
    snes_req = 1'b0;
    lat = 1;
    while (!snes_done && lat < 40) begin tick(); lat++; end
    seen = snes_done;
  endtask

  task automatic mcu_op(input logic we, input logic [23:0] a, input logic [7:0] d,
                        output int lat, output logic seen);
    mcu_we = we; mcu_addr = a; mcu_wdata = d; mcu_req = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin tick(); lat++; seen = mcu_ack; end
    mcu_req = 1'b0;
  endtask

  initial begin
    int lat, n, s_t, m_t, base, op;
    logic seen;
    logic [7:0] v, exp_v;
    logic [23:0] a;

    pad_mem[24'hC00010] = 8'h5A;
    ref_mem[24'hC00010] = 8'h5A;
    repeat (3) tick();
    check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_doe}, 4'b1110);
    check("rst_addr_dout", {ram_addr, ram_dout}, 32'h0);
    check("rst_rdata", {snes_rdata, mcu_rdata}, 16'h0);
    check("rst_flags", {snes_done, mcu_ack, snes_overrun}, 3'b000);
    RST_N = 1'b1;
    repeat (2) tick();

    // Idle SNES read
    snes_op(1'b0, 24'hC00010, 8'h00, lat, seen);
    check("snes_rd_latency", lat, 6);
    check("snes_rd_data", snes_rdata, 8'h5A);
    repeat (2) tick();
    check("snes_rd_oe_len", oe_last, 4);

    // MCU write then read-back
    base = mcu_ack_cnt;
    ref_mem[24'hE00001] = 8'h33;
    mcu_op(1'b1, 24'hE00001, 8'h33, lat, seen);
    check("mcu_wr_ack", seen, 1'b1);
    repeat (3) tick();
    check("mcu_wr_single_ack", mcu_ack_cnt - base, 1);
    check("mcu_wr_we_len", we_last, 3);
    check("mcu_wr_chip", pad_rd(24'hE00001), 8'h33);
    mcu_op(1'b0, 24'hE00001, 8'h00, lat, seen);
    check("mcu_rd_data", mcu_rdata, 8'h33);
    repeat (3) tick();

    // Collision: SNES write and MCU read of the same byte; SNES must go first
    ref_mem[24'h000100] = 8'h9C;
    exp_v = ref_rd(24'h000100);
    snes_we = 1'b1; snes_addr = 24'h000100; snes_wdata = 8'h9C; snes_req = 1'b1;
    mcu_we = 1'b0; mcu_addr = 24'h000100; mcu_req = 1'b1;
    n = 0; s_t = 0; m_t = 0; v = 8'h00;
    while ((s_t == 0 || m_t == 0) && n < 60) begin
      tick(); n++; snes_req = 1'b0;
      if (snes_done && s_t == 0) s_t = n;
      if (mcu_ack && m_t == 0) begin m_t = n; v = mcu_rdata; mcu_req = 1'b0; end
    end
    mcu_req = 1'b0;
    check("collide_both_done", {s_t != 0, m_t != 0}, 2'b11);
    check("collide_snes_first", m_t > s_t, 1'b1);
    check("collide_mcu_data", v, exp_v);
    repeat (3) tick();

    // SNES read arrives during MCU write cycle 2
    ref_mem[24'h000200] = 8'h44;
    mcu_we = 1'b1; mcu_addr = 24'h000200; mcu_wdata = 8'h44; mcu_req = 1'b1;
    n = 0;
    while (ram_ce_n && n < 20) begin tick(); n++; end
    tick();
    snes_we = 1'b0; snes_addr = 24'hC00010; snes_req = 1'b1;
    n = 0; s_t = 0; m_t = 0;
    while ((s_t == 0 || m_t == 0) && n < 40) begin
      tick(); n++; snes_req = 1'b0;
      if (snes_done && s_t == 0) s_t = n;
      if (mcu_ack && m_t == 0) begin m_t = n; mcu_req = 1'b0; end
    end
    mcu_req = 1'b0;
    check("mid_wr_snes_seen", s_t != 0, 1'b1);
    check("mid_wr_snes_bound", (s_t != 0) && (s_t <= 11), 1'b1);
    check("mid_wr_snes_data", snes_rdata, 8'h5A);
    check("mid_wr_chip", pad_rd(24'h000200), 8'h44);
    repeat (3) tick();

    // Overrun: two SNES pulses one idle cycle apart during an MCU read
    check("pre_overrun", snes_overrun, 1'b0);
    base = snes_done_cnt;
    mcu_we = 1'b0; mcu_addr = 24'h000200; mcu_req = 1'b1;
    n = 0;
    while (ram_ce_n && n < 20) begin tick(); n++; end
    tick();
    snes_we = 1'b0; snes_addr = 24'hC00010; snes_req = 1'b1;
    tick(); snes_req = 1'b0;
    tick(); snes_addr = 24'hE00001; snes_req = 1'b1;
    tick(); snes_req = 1'b0;
    v = 8'h00; m_t = 0;
    for (int i = 0; i < 30; i++) begin
      if (mcu_ack && m_t == 0) begin m_t = 1; v = mcu_rdata; mcu_req = 1'b0; end
      tick();
    end
    mcu_req = 1'b0;
    check("overrun_flag", snes_overrun, 1'b1);
    check("overrun_one_done", snes_done_cnt - base, 1);
    check("overrun_kept_first", snes_rdata, 8'h5A);
    check("overrun_mcu_data", v, 8'h44);

    // Reset during SNES read cycle 3
    base = snes_done_cnt;
    snes_we = 1'b0; snes_addr = 24'hE00001; snes_req = 1'b1;
    tick(); snes_req = 1'b0;
    n = 0;
    while (ram_ce_n && n < 20) begin tick(); n++; end
    tick(); tick();
    RST_N = 1'b0;
    #1;
    check("rst_mid_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_doe}, 4'b1110);
    check("rst_mid_overrun", snes_overrun, 1'b0);
    tick(); tick();
    RST_N = 1'b1;
    repeat (10) tick();
    check("rst_mid_no_done", snes_done_cnt - base, 0);
    mcu_op(1'b0, 24'hE00001, 8'h00, lat, seen);
    check("post_rst_mcu_ack", seen, 1'b1);
    check("post_rst_mcu_data", mcu_rdata, ref_rd(24'hE00001));
    repeat (3) tick();

    // Randomized accesses against the reference contents
    for (int i = 0; i < 24; i++) begin
      a = pool[$urandom_range(0, 3)];
      v = 8'($urandom);
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          exp_v = ref_rd(a);
          snes_op(1'b0, a, 8'h00, lat, seen);
          check("rand_snes_rd_latency", lat, 6);
          check("rand_snes_rd_data", snes_rdata, exp_v);
        end
        1: begin
          ref_mem[a] = v;
          snes_op(1'b1, a, v, lat, seen);
          check("rand_snes_wr_done", seen, 1'b1);
        end
        2: begin
          exp_v = ref_rd(a);
          mcu_op(1'b0, a, 8'h00, lat, seen);
          check("rand_mcu_rd_ack", seen, 1'b1);
          check("rand_mcu_rd_data", mcu_rdata, exp_v);
        end
        default: begin
          ref_mem[a] = v;
          mcu_op(1'b1, a, v, lat, seen);
          check("rand_mcu_wr_ack", seen, 1'b1);
        end
      endcase
      repeat (3) tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("final_chip_contents", pad_rd(pool[i]), ref_rd(pool[i]));
    end
    check("we_only_with_doe", bad_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
